regfile_arbiter: RTL

//  Shares the single-port 8x8 register file (one read-pair OR one write per cycle) among
//  NUM_CLIENTS requesters (operand fetch, writeback, debug/loader). Grants at most one

---
 rtl/regfile_arbiter_if.sv | 28 ++
 rtl/regfile_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter_if.sv
// Client-side request/response bundle for regfile_arbiter: per-client request fields
// packed by client index, plus the single tagged read-response channel.
interface regfile_arbiter_if #(
    parameter int NUM_CLIENTS = 3,
    parameter int ID_W        = 2
);
    logic [NUM_CLIENTS-1:0]   req_valid;
    logic [NUM_CLIENTS-1:0]   req_ready;
    logic [NUM_CLIENTS-1:0]   req_we;
    logic [3*NUM_CLIENTS-1:0] req_addr1;
    logic [3*NUM_CLIENTS-1:0] req_addr2;
    logic [3*NUM_CLIENTS-1:0] req_waddr;
    logic [8*NUM_CLIENTS-1:0] req_wdata;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [7:0]               rsp_data1;
    logic [7:0]               rsp_data2;

    modport master (
        output req_valid, req_we, req_addr1, req_addr2, req_waddr, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_data1, rsp_data2
    );

    modport slave (
        input  req_valid, req_we, req_addr1, req_addr2, req_waddr, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_data1, rsp_data2
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Single-port 8x8 register file arbiter: one read-pair or one write per cycle, read data
// returned one cycle later tagged with the client ID. Define RF_ARB_RR_EN for round-robin.
module regfile_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int ID_W        = 2
) (
    input  logic                clk,
    input  logic                reset,
    regfile_arbiter_if.slave    req,
    output logic [2:0]          rf_r_addr1,
    output logic [2:0]          rf_r_addr2,
    output logic [2:0]          rf_w_addr,
    output logic [7:0]          rf_w_data,
    output logic                rf_r_or_w,
    input  logic [7:0]          rf_data1,
    input  logic [7:0]          rf_data2
);

    localparam logic [ID_W:0] NUM_C = (ID_W+1)'(NUM_CLIENTS);

    logic              grant_vld_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [ID_W-1:0]   cand_s;
    logic              sel_we_s;
    logic [2:0]        sel_addr1_s;
    logic [2:0]        sel_addr2_s;
    logic [2:0]        sel_waddr_s;
    logic [7:0]        sel_wdata_s;
    logic              rd_grant_s;
    logic              wr_grant_s;

    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [2:0]        r_addr1_r;
    logic [2:0]        r_addr2_r;
    logic [2:0]        w_addr_r;
    logic [7:0]        w_data_r;

`ifdef RF_ARB_RR_EN
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W:0]     rr_sum_s;
    logic [ID_W:0]     rr_next_s;
`endif

    // Winner selection: first valid client in search order, nothing while in reset
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = '0;
        cand_s      = '0;
`ifdef RF_ARB_RR_EN
        rr_sum_s    = '0;
`endif
        for (int off = 0; off < NUM_CLIENTS; off++) begin
`ifdef RF_ARB_RR_EN
            rr_sum_s = {1'b0, rr_ptr_r} + (ID_W+1)'(off);
            rr_sum_s = (rr_sum_s >= NUM_C) ? (rr_sum_s - NUM_C) : rr_sum_s;
            cand_s   = rr_sum_s[ID_W-1:0];
`else
            cand_s   = ID_W'(off);
`endif
            grant_id_s  = (!grant_vld_s && req.req_valid[cand_s]) ? cand_s : grant_id_s;
            grant_vld_s = grant_vld_s | req.req_valid[cand_s];
        end
        grant_vld_s = grant_vld_s & ~reset;
    end

    // Field mux for the granted client
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr1_s = 3'd0;
        sel_addr2_s = 3'd0;
        sel_waddr_s = 3'd0;
        sel_wdata_s = 8'd0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_id_s == ID_W'(i)) begin
                sel_we_s    = req.req_we[i];
                sel_addr1_s = req.req_addr1[3*i +: 3];
                sel_addr2_s = req.req_addr2[3*i +: 3];
                sel_waddr_s = req.req_waddr[3*i +: 3];
                sel_wdata_s = req.req_wdata[8*i +: 8];
            end else begin
                sel_we_s    = sel_we_s;
            end
        end
    end

    assign rd_grant_s = grant_vld_s & ~sel_we_s;
    assign wr_grant_s = grant_vld_s &  sel_we_s;

    // One-hot grant back to the clients
    always_comb begin
        req.req_ready = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            req.req_ready[i] = grant_vld_s && (grant_id_s == ID_W'(i));
        end
    end

    // Regfile pins follow the winner in its grant cycle and otherwise hold the last value
    assign rf_r_or_w  = wr_grant_s;
    assign rf_r_addr1 = rd_grant_s ? sel_addr1_s : r_addr1_r;
    assign rf_r_addr2 = rd_grant_s ? sel_addr2_s : r_addr2_r;
    assign rf_w_addr  = wr_grant_s ? sel_waddr_s : w_addr_r;
    assign rf_w_data  = wr_grant_s ? sel_wdata_s : w_data_r;

    // A read launched just before reset must not surface during the reset cycle
    assign req.rsp_valid = rsp_valid_r & ~reset;
    assign req.rsp_id    = rsp_id_r;
    assign req.rsp_data1 = rf_data1;
    assign req.rsp_data2 = rf_data2;

    // Response tag and held pin values
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            r_addr1_r   <= 3'd0;
            r_addr2_r   <= 3'd0;
            w_addr_r    <= 3'd0;
            w_data_r    <= 8'd0;
        end else begin
            rsp_valid_r <= rd_grant_s;
            rsp_id_r    <= rd_grant_s ? grant_id_s : rsp_id_r;
            r_addr1_r   <= rf_r_addr1;
            r_addr2_r   <= rf_r_addr2;
            w_addr_r    <= rf_w_addr;
            w_data_r    <= rf_w_data;
        end
    end

`ifdef RF_ARB_RR_EN
    assign rr_next_s = ({1'b0, grant_id_s} + {{ID_W{1'b0}}, 1'b1} >= NUM_C) ?
                       '0 : ({1'b0, grant_id_s} + {{ID_W{1'b0}}, 1'b1});

    // Round-robin pointer: the client after the last winner becomes highest priority
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (grant_vld_s) begin
            rr_ptr_r <= rr_next_s[ID_W-1:0];
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

endmodule
